// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RISC-V style instruction encoder with one ready/valid output stage
module instr_encoder #(
    parameter int ADDRWIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 out_err,
    output logic [ADDRWIDTH-1:0] out_addr,
    output logic [7:0]           err_cnt
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic                 r_valid;
    logic [31:0]          r_instr;
    logic                 r_err;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [7:0]           r_cnt;

    logic        w_accept;
    logic        w_xfer;
    logic        w_shift;
    logic        w_fit12;
    logic        w_fit13;
    logic        w_fit21;
    logic        w_legal;
    logic [31:0] w_word;
    logic [31:0] w_instr;

    assign in_ready = !rst_n || !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_valid && out_ready;

    // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
    assign w_fit12 = (&imm[31:11]) || !(|imm[31:11]);
    assign w_fit13 = (&imm[31:12]) || !(|imm[31:12]);
    assign w_fit21 = (&imm[31:20]) || !(|imm[31:20]);
    assign w_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        w_legal = 1'b0;
        w_word  = NOP;
        case (fmt)
            3'd0: begin
                w_legal = w_fit12;
                w_word  = w_shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                                  : {imm[11:0], rs1, funct3, rd, opcode};
            end
            3'd1: begin
                w_legal = w_fit12;
                w_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            3'd2: begin
                w_legal = w_fit13 && !imm[0];
                w_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            3'd3: begin
                w_legal = w_fit21 && !imm[0];
                w_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            3'd4: begin
                w_legal = (imm[11:0] == 12'd0);
                w_word  = {imm[31:12], rd, opcode};
            end
            default: begin
                w_legal = 1'b0;
                w_word  = NOP;
            end
        endcase
        w_instr = w_legal ? w_word : NOP;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= 8'd0;
        end else begin
            if (w_xfer) begin
                r_addr <= r_addr + ADDRWIDTH'(4);
            end
            if (w_accept) begin
                r_valid <= 1'b1;
                r_instr <= w_instr;
                r_err   <= !w_legal;
                if (!w_legal && (r_cnt != 8'hff)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign instr     = r_instr;
    assign out_err   = r_err;
    assign out_addr  = r_addr;
    assign err_cnt   = r_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed checks of instr_encoder against a behavioural model
module tb_instr_encoder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [31:0] instr;
    logic [11:0] out_addr;
    logic [7:0]  err_cnt;
    logic        in_ready_4, out_valid_4, out_err_4;
    logic [31:0] instr_4;
    logic [3:0]  out_addr_4;
    logic [7:0]  err_cnt_4;

    int total = 0;
    int bad   = 0;

    // Model state: what the output stage must hold after each edge.
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_err;
    logic        m_fresh;
    int          m_addr;
    int          m_cnt;
    logic [2:0]  m_fmt;
    logic [31:0] m_imm;
    logic        m_shift;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .out_err(out_err), .out_addr(out_addr), .err_cnt(err_cnt)
    );

    instr_encoder #(.ADDRWIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_4),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid_4), .out_ready(out_ready), .instr(instr_4),
        .out_err(out_err_4), .out_addr(out_addr_4), .err_cnt(err_cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Returns {illegal, word} straight from the format tables and numeric ranges.
    function automatic logic [32:0] model_enc(input logic [2:0] f, input logic [31:0] im,
                                              input logic [6:0] op, input logic [4:0] d,
                                              input logic [4:0] s1, input logic [4:0] s2,
                                              input logic [2:0] f3, input logic [6:0] f7);
        int          s;
        logic        ok;
        logic [31:0] w;
        s  = $signed(im);
        ok = 1'b0;
        w  = 32'h13;
        case (f)
            3'd0: begin
                ok = (s >= -2048) && (s <= 2047);
                if (f3 == 3'b001 || f3 == 3'b101) w = {f7, im[4:0], s1, f3, d, op};
                else                              w = {im[11:0], s1, f3, d, op};
            end
            3'd1: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = {im[11:5], s2, s1, f3, im[4:0], op};
            end
            3'd2: begin
                ok = (s >= -4096) && (s <= 4094) && (im[0] == 1'b0);
                w  = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
            end
            3'd3: begin
                ok = (s >= -1048576) && (s <= 1048574) && (im[0] == 1'b0);
                w  = {im[20], im[10:1], im[11], im[19:12], d, op};
            end
            3'd4: begin
                ok = (im % 4096) == 0;
                w  = {im[31:12], d, op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h13};
    endfunction

    // Immediate generator as a core decoder would see the word.
    function automatic logic [31:0] immgen(input logic [31:0] w, input logic [2:0] f);
        case (f)
            3'd0:    return {{20{w[31]}}, w[31:20]};
            3'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd2:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd3:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return {w[31:12], 12'd0};
        endcase
    endfunction

    // Inputs are set just after a falling edge; this samples in_ready, advances one
    // clock in both DUT and model, then compares registered outputs at the next falling edge.
    task automatic cycle();
        logic        exp_rdy, acc, xfer;
        logic        n_valid, n_err, n_fresh;
        logic [31:0] n_instr;
        logic [32:0] e;
        int          n_addr, n_cnt;
        #1;
        exp_rdy = !rst_n || !m_valid || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready4", in_ready_4, exp_rdy);
        n_valid = m_valid; n_instr = m_instr; n_err = m_err; n_fresh = m_fresh;
        n_addr = m_addr; n_cnt = m_cnt;
        if (!rst_n) begin
            n_valid = 0; n_instr = 0; n_err = 0; n_addr = 0; n_cnt = 0; n_fresh = 1;
        end else begin
            acc  = in_valid && exp_rdy;
            xfer = m_valid && out_ready;
            if (xfer) n_addr = (m_addr + 4) % 65536;
            if (acc) begin
                e = model_enc(fmt, imm, opcode, rd, rs1, rs2, funct3, funct7);
                n_valid = 1; n_err = e[32]; n_instr = e[31:0]; n_fresh = 0;
                if (e[32] && m_cnt < 255) n_cnt = m_cnt + 1;
            end else if (xfer) begin
                n_valid = 0;
            end
        end
        @(posedge clk);
        if (rst_n && in_valid && exp_rdy) begin
            m_fmt = fmt; m_imm = imm; m_shift = (funct3 == 3'b001 || funct3 == 3'b101);
        end
        m_valid = n_valid; m_instr = n_instr; m_err = n_err; m_fresh = n_fresh;
        m_addr = n_addr; m_cnt = n_cnt;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        chk("out_valid4", out_valid_4, m_valid);
        chk("out_addr", out_addr, m_addr % 4096);
        chk("out_addr4", out_addr_4, m_addr % 16);
        chk("err_cnt", err_cnt, m_cnt);
        chk("err_cnt4", err_cnt_4, m_cnt);
        if (m_valid || m_fresh) begin
            chk("instr", instr, m_instr);
            chk("instr4", instr_4, m_instr);
            chk("out_err", out_err, m_err);
        end
        if (m_valid && !m_err && !(m_fmt == 3'd0 && m_shift))
            chk("roundtrip", immgen(instr, m_fmt), m_imm);
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] im, input logic [6:0] op,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [2:0] f3);
        fmt = f; imm = im; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h20;
    endtask

    task automatic rand_req();
        int sel;
        fmt    = ($urandom % 8 < 6) ? 3'($urandom % 5) : 3'($urandom % 8);
        opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        sel = $urandom % 6;
        case (sel)
            0: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
            1: imm = 32'(($signed($urandom_range(0, 4095)) - 2048) * 2);
            2: imm = 32'(($signed($urandom_range(0, 1048575)) - 524288) * 2);
            3: imm = {20'($urandom), 12'd0};
            4: begin
                case ($urandom % 8)
                    0: imm = 32'd2047;   1: imm = 32'd2048;   2: imm = -32'sd2048;
                    3: imm = -32'sd2049; 4: imm = 32'd4094;   5: imm = 32'd4096;
                    6: imm = 32'd1048574; default: imm = -32'sd1048578;
                endcase
                if ($urandom % 4 == 0) imm[0] = 1'b1;
            end
            default: imm = $urandom;
        endcase
    endtask

    initial begin
        int addrs[5] = '{0, 4, 8, 12, 0};
        m_valid = 0; m_instr = 0; m_err = 0; m_fresh = 1; m_addr = 0; m_cnt = 0;
        m_fmt = 0; m_imm = 0; m_shift = 0;
        rst_n = 0; in_valid = 1; out_ready = 0;
        set_req(3'd0, 32'd5, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0);
        @(negedge clk);
        cycle();
        cycle();
        chk("reset_valid", out_valid, 0);
        chk("reset_instr", instr, 0);
        chk("reset_cnt", err_cnt, 0);

        rst_n = 1; out_ready = 1;
        set_req(3'd2, -32'sd4096, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        cycle();
        chk("b_min_instr", instr, 32'h80208063);
        chk("b_min_err", out_err, 0);
        chk("b_min_valid", out_valid, 1);

        set_req(3'd3, 32'd3, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0);
        cycle();
        chk("j_odd_err", out_err, 1);
        set_req(3'd4, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        cycle();
        chk("u_instr", instr, 32'h123452B7);

        rst_n = 0; cycle(); rst_n = 1;
        set_req(3'd0, 32'd2048, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
        cycle();
        chk("i_over_instr", instr, 32'h00000013);
        chk("i_over_err", out_err, 1);
        chk("i_over_cnt", err_cnt, 1);
        fmt = 3'd7;
        for (int i = 0; i < 300; i++) cycle();
        chk("cnt_sat", err_cnt, 255);

        set_req(3'd1, 32'd100, 7'h23, 5'd0, 5'd3, 5'd4, 3'd2);
        cycle();
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            cycle();
            chk("stall_ready", in_ready, 0);
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            set_req(3'd0, 32'(i * 8), 7'h13, 5'(i), 5'd2, 5'd0, 3'd0);
            cycle();
            chk("b2b_valid", out_valid, 1);
        end

        rst_n = 0; cycle(); rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            set_req(3'd0, 32'(i), 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
            cycle();
            chk("addr4_seq", out_addr_4, addrs[i]);
        end

        out_ready = 0;
        set_req(3'd0, 32'd9999, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
        cycle();
        rst_n = 0;
        cycle();
        chk("rst_hold_valid", out_valid, 0);
        chk("rst_hold_addr", out_addr, 0);
        chk("rst_hold_cnt", err_cnt, 0);
        rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom % 200) != 0;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            rand_req();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDRWIDTH, default 12; width of out_addr.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request carries a field set to encode.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 fmt  input  3  format: 0=I, 1=S, 2=B, 3=J, 4=U; 5-7 are illegal.
REQ-007 opcode  input  7  placed unchanged in instr[6:0].
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3; funct7  input  7  function fields.
REQ-010 imm  input  32  signed byte-offset immediate.
REQ-011 out_valid  output  1  instr/out_err/out_addr are valid.
REQ-012 out_ready  input  1  consumer takes the output this cycle.
REQ-013 instr  output  32  encoded instruction word.
REQ-014 out_err  output  1  the request was illegal; instr is a NOP.
REQ-015 out_addr  output  ADDRWIDTH  byte address of this word.
REQ-016 err_cnt  output  8  saturating count of illegal requests accepted.

Function
REQ-017 A single output register stage; in_ready = !out_valid || out_ready (combinational).
REQ-018 Accept when in_valid && in_ready; instr, out_err and out_valid=1 load on the next edge (latency 1).
REQ-019 Transfer when out_valid && out_ready; with no simultaneous accept, out_valid clears on the next edge.
REQ-020 Simultaneous transfer and accept: out_valid stays 1, new word loads, no bubble.
REQ-021 Output fields hold stable while out_valid && !out_ready; in_valid is then ignored.
REQ-022 I: instr = imm[11:0], rs1, funct3, rd, opcode.
REQ-023 S: instr = imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
REQ-024 B: instr = imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
REQ-025 J: instr = imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
REQ-026 U: instr = imm[31:12], rd, opcode.
REQ-027 funct7 is used only when fmt=I and funct3 is 3'b001 or 3'b101: instr[31:25] = funct7 and instr[24:20] = imm[4:0].
REQ-028 Legal ranges, signed two's complement: I/S -2048..2047; B -4096..4094 and even; J -1048576..1048574 and even; U requires imm[11:0] == 0.
REQ-029 Out-of-range value, odd B/J offset, or illegal fmt: out_err = 1 and instr = 32'h00000013.
REQ-030 out_addr starts at 0 and increments by 4 on each transfer, modulo 2^ADDRWIDTH (wraps to 0).
REQ-031 err_cnt increments by 1 on each accepted illegal request and saturates at 255.
REQ-032 Legal requests round-trip: feeding instr to the core's IMMGEN returns imm exactly.

Reset
REQ-033 When rst_n = 0 at an edge, the next state is: out_valid=0, instr=0, out_err=0, out_addr=0, err_cnt=0.
REQ-034 Reset mid-transfer discards the held word; no transfer is counted.
REQ-035 While rst_n = 0, in_ready = 1 and requests are not captured.

Verification
REQ-036 Accept fmt=B, imm=-4096, opcode=7'h63, rs1=1, rs2=2, funct3=0 -> next cycle instr=32'h80208063, out_err=0, out_valid=1.
REQ-037 Accept fmt=I, imm=2048 -> instr=32'h00000013, out_err=1, err_cnt=1; then 300 more illegal requests -> err_cnt=255.
REQ-038 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and instr stable; on release, back-to-back accepts give one word per cycle.
REQ-039 With ADDRWIDTH=4, 5 transfers -> out_addr sequence 0, 4, 8, 12, 0.
REQ-040 Accept fmt=J, imm=3 -> out_err=1; fmt=U, imm=32'h12345000, rd=5, opcode=7'h37 -> instr=32'h123452B7.
REQ-041 Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=0, err_cnt=0.
